count_sched: RTL and testbench

- Round-robin scheduler that shares one 8-bit loadable up-counter (sync active-low clear, load, carry-in, carry-out = &{q,ci}) among N requesters as a one-shot interval timer.
- Each requester asks for a delay of `len` cycles. The block arbitrates between requesters, loads the counter, enables counting, and pulses `done` to the winner when the counter carries out.
- It sits between the requesting control FSMs and the counter instance, and drives every counter input.

---
 rtl/count_sched.sv | 106 ++++++++++
 tb/tb_count_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one 8-bit loadable up-counter among N requesters as a one-shot interval timer.
// Interval is len+3 cycles from request sample to done pulse; requests wait (held) while another interval runs.
module count_sched #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [7:0]     rem,
  output logic [7:0]     cnt_d,
  output logic           cnt_ld,
  output logic           cnt_ci,
  output logic           cnt_rst_n,
  input  logic           cnt_co,
  input  logic [7:0]     cnt_q
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   sel_nxt;
  logic            found;
  logic [7:0]      cur_len;
  logic            cur_req;

  // Two passes give the first set bit at or above ptr, wrapping to the lowest set bit.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
    sel_nxt = (sel == PW'(N-1)) ? '0 : sel + PW'(1);
  end

  always_comb begin
    cur_len = 8'h00;
    cur_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx == PW'(i)) begin
        cur_len = len[8*i +: 8];
        cur_req = req[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx   <= sel;
            ptr   <= sel_nxt;
            state <= LOAD;
          end
        end
        LOAD: state <= cur_req ? RUN : IDLE;
        // Carry-out beats a dropped request in the same cycle.
        RUN: begin
          if (cnt_co)        state <= DONE;
          else if (!cur_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i]  = ((state == LOAD) || (state == RUN)) && (idx == PW'(i));
      done[i] = (state == DONE) && (idx == PW'(i));
    end
  end

  // Counter starts at ~len so it reaches 8'hFF, and carries out, after len steps.
  assign busy      = (state != IDLE);
  assign cnt_rst_n = (state == LOAD) || (state == RUN);
  assign cnt_ld    = (state == LOAD);
  assign cnt_ci    = (state == RUN);
  assign cnt_d     = (state == LOAD) ? ~cur_len : 8'h00;
  assign rem       = (state == RUN) ? ~cnt_q : 8'h00;

endmodule

// File: tb/tb_count_sched.sv
// Randomized bench for count_sched: round-robin/interval reference model feeding a cycle-stamped scoreboard.
module tb_count_sched;
  localparam int N  = 4;
  localparam int PW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] len;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [7:0]     rem, cnt_d;
  logic           cnt_ld, cnt_ci, cnt_rst_n, cnt_co;
  logic [7:0]     cnt_q;

  count_sched #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .done(done),
    .busy(busy), .rem(rem), .cnt_d(cnt_d), .cnt_ld(cnt_ld), .cnt_ci(cnt_ci),
    .cnt_rst_n(cnt_rst_n), .cnt_co(cnt_co), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared 8-bit counter: sync active-low clear, load, carry-in.
  always @(posedge clk) begin
    if (!cnt_rst_n)  cnt_q <= 8'h00;
    else if (cnt_ld) cnt_q <= cnt_d;
    else if (cnt_ci) cnt_q <= cnt_q + 8'h01;
  end
  assign cnt_co = &{cnt_q, cnt_ci};

  // One expected interval: requester, IDLE cycle it was sampled in, length, and cancel point.
  typedef struct {
    int idx;
    int start;
    int len;
    bit cancel;
    int cend;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ptr_m    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rem"}, int'(rem), 0);
    chk({tag, "_cnt_d"}, int'(cnt_d), 0);
    chk({tag, "_cnt_ld"}, int'(cnt_ld), 0);
    chk({tag, "_cnt_ci"}, int'(cnt_ci), 0);
    chk({tag, "_cnt_rst_n"}, int'(cnt_rst_n), 0);
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Monitor: derive every output for this cycle from the front scoreboard entry.
  exp_t         e;
  int           c, ld_c, end_c;
  logic [N-1:0] e_gnt, e_done;
  logic [7:0]   e_rem, e_d;
  logic         e_busy, e_ld, e_ci, e_rstn, popit;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        c = cyc;
        e_gnt = '0; e_done = '0; e_rem = 8'h00; e_d = 8'h00;
        e_busy = 1'b0; e_ld = 1'b0; e_ci = 1'b0; e_rstn = 1'b0; popit = 1'b0;
        if (sb.size() > 0) begin
          e     = sb[0];
          ld_c  = e.start + 1;
          end_c = e.cancel ? e.cend : e.start + e.len + 3;
          if (c == ld_c) begin
            e_busy = 1'b1; e_gnt[e.idx] = 1'b1; e_ld = 1'b1; e_rstn = 1'b1;
            e_d = 8'(255 - e.len);
          end else if (c > ld_c && c < end_c) begin
            e_busy = 1'b1; e_gnt[e.idx] = 1'b1; e_ci = 1'b1; e_rstn = 1'b1;
            e_rem = 8'(e.len - (c - ld_c - 1));
          end else if (c >= end_c) begin
            if (!e.cancel && c == end_c) begin
              e_busy = 1'b1; e_done[e.idx] = 1'b1;
            end
            popit = 1'b1;
          end
        end
        chk("gnt", int'(gnt), int'(e_gnt));
        chk("done", int'(done), int'(e_done));
        chk("busy", int'(busy), int'(e_busy));
        chk("rem", int'(rem), int'(e_rem));
        chk("cnt_d", int'(cnt_d), int'(e_d));
        chk("cnt_ld", int'(cnt_ld), int'(e_ld));
        chk("cnt_ci", int'(cnt_ci), int'(e_ci));
        chk("cnt_rst_n", int'(cnt_rst_n), int'(e_rstn));
        chk("gnt_onehot0", int'($countones(gnt) <= 1), 1);
        chk("done_onehot0", int'($countones(done) <= 1), 1);
        chk("ld_ci_exclusive", int'(cnt_ld && cnt_ci), 0);
        if (popit) void'(sb.pop_front());
      end
    end
  end

  // Hold mask m for s services in round-robin order, then release all requests.
  task automatic run_sched(input logic [N-1:0] m, input logic [8*N-1:0] l, input int s);
    int   p, w, st, dn;
    exp_t x;
    @(negedge clk);
    req = m; len = l; st = cyc; p = ptr_m; dn = st;
    for (int k = 0; k < s; k++) begin
      w = pick(m, p);
      x.idx = w; x.start = st; x.len = int'(l[8*w +: 8]); x.cancel = 1'b0; x.cend = 0;
      sb.push_back(x);
      dn = st + x.len + 3;
      p  = (w + 1) % N;
      st = dn + 1;
    end
    ptr_m = p;
    if (s == 1) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) len[8*i +: 8] = 8'($urandom);
    end
    while (cyc < dn) @(negedge clk);
    req = '0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   st, w, dn;
    exp_t x;
    rst = 1'b1; req = '0; len = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sched(4'b1011, {4{8'd2}}, 4);
    run_sched(4'b0001, {24'h0, 8'd5}, 1);
    run_sched(4'b0100, 32'h0, 1);
    run_sched(4'b0100, {8'h0, 8'd255, 16'h0}, 1);

    for (int r = 0; r < 25; r++) begin
      logic [8*N-1:0] l;
      for (int i = 0; i < N; i++) l[8*i +: 8] = 8'($urandom_range(0, 12));
      run_sched(N'($urandom_range(1, 15)), l, $urandom_range(1, 5));
    end

    // Asynchronous reset in the middle of a RUN interval.
    @(negedge clk);
    req = 4'b0110; len = {4{8'd8}}; st = cyc; w = pick(req, ptr_m);
    x.idx = w; x.start = st; x.len = 8; x.cancel = 1'b0; x.cend = 0;
    sb.push_back(x);
    ptr_m = (w + 1) % N;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    sb.delete();
    ptr_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cancel in the third RUN cycle; the pending requester wins next.
    req = 4'b0110; len = {8'd0, 8'd3, 8'd10, 8'd0}; st = cyc;
    w = pick(req, ptr_m);
    x.idx = w; x.start = st; x.len = 10; x.cancel = 1'b1; x.cend = st + 5;
    sb.push_back(x);
    ptr_m = (w + 1) % N;
    w = pick(4'b0100, ptr_m);
    x.idx = w; x.start = st + 5; x.len = 3; x.cancel = 1'b0; x.cend = 0;
    sb.push_back(x);
    ptr_m = (w + 1) % N;
    dn = st + 5 + 3 + 3;
    while (cyc < st + 4) @(negedge clk);
    req[1] = 1'b0;
    while (cyc < dn) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Request dropped in the carry-out cycle still completes.
    req = 4'b0010; len = {8'd0, 8'd0, 8'd4, 8'd0}; st = cyc;
    w = pick(req, ptr_m);
    x.idx = w; x.start = st; x.len = 4; x.cancel = 1'b0; x.cend = 0;
    sb.push_back(x);
    ptr_m = (w + 1) % N;
    dn = st + 4 + 3;
    while (cyc < dn - 1) @(negedge clk);
    req = '0;
    while (cyc < dn) @(negedge clk);
    repeat (5) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
